// File: rtl/fib_request_scheduler_if.sv
// Requester-side handshake bundle for fib_request_scheduler: job requests in,
// one-hot grants and results back out.
interface fib_request_scheduler_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*5-1:0] req_n;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [15:0]       rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_n, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_n, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/fib_request_scheduler.sv
// Round-robin scheduler sharing one fibonacci calculator between NREQ requesters:
// arbitrates, range-checks, sequences clear/launch/wait and returns the result.
module fib_request_scheduler #(
  parameter int NREQ    = 4,
  parameter int MAX_N   = 24,
  parameter int TIMEOUT = 63
) (
  input  logic                          clk,
  input  logic                          reset_n,
  fib_request_scheduler_if.slave        bus,
  output logic                          busy,
  output logic                          calc_reset,
  output logic                          calc_begin,
  output logic [4:0]                    calc_input_s,
  input  logic                          calc_done,
  input  logic [15:0]                   calc_out
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LAUNCH  = 3'd2,
    S_WAIT    = 3'd3,
    S_RESPOND = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [4:0]      n_q, n_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            calc_reset_q, calc_reset_d;
  logic            calc_begin_q, calc_begin_d;
  logic [4:0]      calc_input_s_q, calc_input_s_d;
  logic            busy_q, busy_d;

  logic            arb_found_s;
  logic [IW-1:0]   arb_idx_s;
  logic [IW:0]     arb_cand_s;
  logic [IW:0]     rr_inc_s;
  logic [IW-1:0]   rr_next_s;
  logic [4:0]      arb_n_s;
  logic            arb_bad_s;
  logic [NREQ-1:0] req_ready_s;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = (idx == IW'(i));
    end
    return v;
  endfunction

  // Round-robin arbiter: first requester at or after the pointer, wrapping.
  always_comb begin
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    arb_cand_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      arb_cand_s = {1'b0, rr_q} + (IW+1)'(k);
      if (arb_cand_s >= (IW+1)'(NREQ)) begin
        arb_cand_s = arb_cand_s - (IW+1)'(NREQ);
      end else begin
        arb_cand_s = arb_cand_s;
      end
      if (!arb_found_s && bus.req_valid[arb_cand_s[IW-1:0]]) begin
        arb_found_s = 1'b1;
        arb_idx_s   = arb_cand_s[IW-1:0];
      end else begin
        arb_found_s = arb_found_s;
      end
    end
    rr_inc_s = {1'b0, arb_idx_s} + (IW+1)'(1);
    if (rr_inc_s >= (IW+1)'(NREQ)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = rr_inc_s[IW-1:0];
    end
    arb_n_s   = bus.req_n[5*int'(arb_idx_s) +: 5];
    arb_bad_s = (arb_n_s == 5'd0) || (arb_n_s > 5'(MAX_N));
  end

  // Job sequencer: next state and next values of every registered output.
  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    gnt_d          = gnt_q;
    n_d            = n_q;
    timer_d        = timer_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    calc_reset_d   = calc_reset_q;
    calc_begin_d   = 1'b0;
    calc_input_s_d = calc_input_s_q;
    req_ready_s    = '0;

    case (state_q)
      S_IDLE: begin
        calc_reset_d = 1'b1;
        if (arb_found_s && reset_n) begin
          req_ready_s = onehot(arb_idx_s);
          gnt_d       = arb_idx_s;
          n_d         = arb_n_s;
          rr_d        = rr_next_s;
          if (arb_bad_s) begin
            state_d     = S_RESPOND;
            rsp_valid_d = onehot(arb_idx_s);
            rsp_data_d  = 16'd0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = S_CLEAR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_d        = S_LAUNCH;
        calc_reset_d   = 1'b0;
        calc_begin_d   = 1'b1;
        calc_input_s_d = n_q;
        timer_d        = '0;
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the final timer cycle still counts as a good result.
        if (calc_done) begin
          state_d      = S_RESPOND;
          rsp_valid_d  = onehot(gnt_q);
          rsp_data_d   = calc_out;
          rsp_err_d    = 1'b0;
          calc_reset_d = 1'b1;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d      = S_RESPOND;
          rsp_valid_d  = onehot(gnt_q);
          rsp_data_d   = 16'd0;
          rsp_err_d    = 1'b1;
          calc_reset_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESPOND: begin
        calc_reset_d = 1'b1;
        if (bus.rsp_ready[gnt_q]) begin
          state_d     = S_IDLE;
          rsp_valid_d = '0;
        end else begin
          state_d = S_RESPOND;
        end
      end
      default: begin
        state_d      = S_IDLE;
        rsp_valid_d  = '0;
        calc_reset_d = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      rr_q           <= '0;
      gnt_q          <= '0;
      n_q            <= 5'd0;
      timer_q        <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= 16'd0;
      rsp_err_q      <= 1'b0;
      calc_reset_q   <= 1'b1;
      calc_begin_q   <= 1'b0;
      calc_input_s_q <= 5'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      gnt_q          <= gnt_d;
      n_q            <= n_d;
      timer_q        <= timer_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_err_q      <= rsp_err_d;
      calc_reset_q   <= calc_reset_d;
      calc_begin_q   <= calc_begin_d;
      calc_input_s_q <= calc_input_s_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = busy_q;
  assign calc_reset    = calc_reset_q;
  assign calc_begin    = calc_begin_q;
  assign calc_input_s  = calc_input_s_q;

endmodule

// File: tb/tb_fib_request_scheduler.sv
// Directed bench for fib_request_scheduler with a behavioural fibonacci calculator.
module tb_fib_request_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        busy, calc_reset, calc_begin, calc_done;
  logic [4:0]  calc_input_s;
  logic [15:0] calc_out;

  fib_request_scheduler_if #(.NREQ(4)) bus ();

  fib_request_scheduler #(.NREQ(4), .MAX_N(24), .TIMEOUT(63)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy),
    .calc_reset(calc_reset), .calc_begin(calc_begin), .calc_input_s(calc_input_s),
    .calc_done(calc_done), .calc_out(calc_out)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int grant_cnt = 0, begin_cnt = 0, begin_cyc = 0, rsp_rise = 0, oh_viol = 0;
  logic [4:0]  begin_n = 5'd0;
  logic        rsp_prev = 1'b0;
  int          grant_log[$];
  logic [15:0] rsp_log[$];
  bit          calc_stuck = 1'b0;
  int          lat_override = 0;
  int          remain = 0;

  function automatic logic [15:0] fib(input logic [4:0] n);
    logic [15:0] a, b, t;
    a = 16'd0; b = 16'd1;
    for (int i = 0; i < int'(n); i++) begin t = a + b; a = b; b = t; end
    return a;
  endfunction

  function automatic int calc_lat(input logic [4:0] n, input int ovr);
    if (ovr != 0) return ovr;
    return (n <= 5'd2) ? 1 : int'(n);
  endfunction

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Calculator model: done n cycles after launch (1 for n<=2), held until reset.
  initial begin calc_done = 1'b0; calc_out = 16'd0; end
  always @(posedge clk) begin
    if (calc_reset) begin
      calc_done <= 1'b0;
      remain    <= 0;
    end else if (calc_begin) begin
      remain    <= calc_lat(calc_input_s, lat_override) - 1;
      calc_done <= (calc_lat(calc_input_s, lat_override) == 1) && !calc_stuck;
      calc_out  <= fib(calc_input_s);
    end else if (remain > 0) begin
      remain    <= remain - 1;
      calc_done <= (remain == 1) && !calc_stuck;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Observation of handshakes and calculator launches, mid low phase.
  always @(negedge clk) begin
    #3;
    if ((bus.req_valid & bus.req_ready) != 4'd0) begin
      grant_cnt <= grant_cnt + 1;
      grant_log.push_back(idx_of(bus.req_valid & bus.req_ready));
    end
    if (calc_begin) begin
      begin_cnt <= begin_cnt + 1;
      begin_n   <= calc_input_s;
      begin_cyc <= cyc;
    end
    if ((bus.rsp_valid & bus.rsp_ready) != 4'd0) rsp_log.push_back(bus.rsp_data);
    if (bus.rsp_valid != 4'd0 && !rsp_prev) rsp_rise <= rsp_rise + 1;
    rsp_prev <= (bus.rsp_valid != 4'd0);
    if ($countones(bus.req_ready) > 1 || $countones(bus.rsp_valid) > 1) oh_viol <= oh_viol + 1;
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic issue(input int i, input logic [4:0] n, output bit ok);
    step();
    bus.req_n[5*i +: 5] = n;
    bus.req_valid[i]    = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      #1;
      if (bus.req_ready[i]) ok = 1'b1;
      step();
    end
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic await_rsp(input int i, output bit ok, output logic [15:0] d,
                           output logic e, output int lat);
    ok = 1'b0; d = 16'hxxxx; e = 1'bx; lat = -1;
    for (int c = 0; c < 400 && !ok; c++) begin
      step();
      if (bus.rsp_valid[i]) begin
        ok = 1'b1; d = bus.rsp_data; e = bus.rsp_err; lat = cyc - begin_cyc;
        bus.rsp_ready[i] = 1'b1;
      end
    end
    step();
    bus.rsp_ready[i] = 1'b0;
  endtask

  task automatic test_reset();
    logic [32:0] got;
    bus.req_valid = 4'd0; bus.rsp_ready = 4'd0; bus.req_n = 20'd0;
    reset_n = 1'b0;
    repeat (3) step();
    got = {busy, bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, calc_begin, calc_input_s, calc_reset};
    checks++;
    if (got !== {1'b0, 4'd0, 4'd0, 16'd0, 1'b0, 1'b0, 5'd0, 1'b1}) begin
      errors++; $display("FAIL reset_values: got %h expected %h", got, {1'b0, 4'd0, 4'd0, 16'd0, 1'b0, 1'b0, 5'd0, 1'b1});
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    bit ok_i, ok_r; logic [15:0] d; logic e; int lat, g0, b0;
    g0 = grant_cnt; b0 = begin_cnt;
    issue(0, 5'd10, ok_i);
    await_rsp(0, ok_r, d, e, lat);
    checks++; if (!(ok_i && ok_r)) begin errors++; $display("FAIL single_handshake: got %0d/%0d expected 1/1", ok_i, ok_r); end
    checks++; if (d !== 16'd55) begin errors++; $display("FAIL single_data: got %0d expected 55", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", e); end
    checks++; if (grant_cnt - g0 != 1) begin errors++; $display("FAIL single_grants: got %0d expected 1", grant_cnt - g0); end
    checks++; if (begin_cnt - b0 != 1) begin errors++; $display("FAIL single_begin_pulses: got %0d expected 1", begin_cnt - b0); end
    checks++; if (begin_n !== 5'd10) begin errors++; $display("FAIL single_input_s: got %0d expected 10", begin_n); end
    checks++; if (lat != 11) begin errors++; $display("FAIL single_latency: got %0d expected 11", lat); end
  endtask

  task automatic test_range();
    logic [4:0]  nv[5] = '{5'd1, 5'd2, 5'd24, 5'd0, 5'd25};
    logic [15:0] dv[5] = '{16'd1, 16'd1, 16'd46368, 16'd0, 16'd0};
    logic        ev[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit ok_i, ok_r; logic [15:0] d; logic e; int lat, b0;
    for (int k = 0; k < 5; k++) begin
      b0 = begin_cnt;
      issue(1, nv[k], ok_i);
      await_rsp(1, ok_r, d, e, lat);
      checks++; if (!(ok_i && ok_r) || d !== dv[k] || e !== ev[k]) begin
        errors++; $display("FAIL range_n%0d: got ok=%0d data=%0d err=%b expected data=%0d err=%b", nv[k], ok_i && ok_r, d, e, dv[k], ev[k]);
      end
      checks++; if (begin_cnt - b0 != (ev[k] ? 0 : 1)) begin
        errors++; $display("FAIL range_begin_n%0d: got %0d pulses expected %0d", nv[k], begin_cnt - b0, ev[k] ? 0 : 1);
      end
    end
  endtask

  task automatic test_round_robin();
    int          exp_g[6] = '{0, 2, 3, 0, 2, 3};
    logic [15:0] exp_d[6] = '{16'd5, 16'd8, 16'd13, 16'd5, 16'd8, 16'd13};
    do_reset();
    grant_log.delete(); rsp_log.delete();
    bus.req_n     = {5'd7, 5'd6, 5'd0, 5'd5};
    bus.rsp_ready = 4'b1111;
    bus.req_valid = 4'b1101;
    for (int c = 0; c < 400 && rsp_log.size() < 6; c++) step();
    bus.req_valid = 4'd0;
    bus.rsp_ready = 4'd0;
    step();
    checks++; if (grant_log.size() != 6 || rsp_log.size() != 6) begin
      errors++; $display("FAIL rr_counts: got grants=%0d rsps=%0d expected 6/6", grant_log.size(), rsp_log.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++; if (grant_log[k] != exp_g[k] || rsp_log[k] !== exp_d[k]) begin
          errors++; $display("FAIL rr_job%0d: got req%0d data=%0d expected req%0d data=%0d", k, grant_log[k], rsp_log[k], exp_g[k], exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    bit ok_i, ok_r, seen; logic [15:0] d; logic e; int lat, g0, bad;
    issue(0, 5'd12, ok_i);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin step(); seen = bus.rsp_valid[0]; end
    checks++; if (!(ok_i && seen)) begin errors++; $display("FAIL bp_rsp_seen: got %0d/%0d expected 1/1", ok_i, seen); end
    bus.req_n[9:5] = 5'd3; bus.req_valid[1] = 1'b1; bus.rsp_ready[2] = 1'b1;
    g0 = grant_cnt; bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 16'd144 || bus.rsp_err !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
    checks++; if (grant_cnt != g0) begin errors++; $display("FAIL bp_no_grant: got %0d grants expected 0", grant_cnt - g0); end
    bus.rsp_ready = 4'b0001;
    step();
    bus.rsp_ready = 4'd0;
    for (int c = 0; c < 20 && grant_cnt == g0; c++) step();
    bus.req_valid[1] = 1'b0;
    checks++; if (grant_cnt - g0 != 1) begin errors++; $display("FAIL bp_next_grant: got %0d expected 1", grant_cnt - g0); end
    await_rsp(1, ok_r, d, e, lat);
    checks++; if (!ok_r || d !== 16'd2 || e !== 1'b0) begin errors++; $display("FAIL bp_next_data: got %0d err=%b expected 2 err=0", d, e); end
  endtask

  task automatic test_timeout();
    bit ok_i, ok_r; logic [15:0] d; logic e; int lat;
    calc_stuck = 1'b1;
    issue(2, 5'd9, ok_i);
    await_rsp(2, ok_r, d, e, lat);
    calc_stuck = 1'b0;
    checks++; if (!(ok_i && ok_r) || e !== 1'b1 || d !== 16'd0) begin errors++; $display("FAIL timeout_err: got data=%0d err=%b expected 0 err=1", d, e); end
    checks++; if (lat != 64) begin errors++; $display("FAIL timeout_latency: got %0d expected 64", lat); end
    lat_override = 63;
    issue(2, 5'd9, ok_i);
    await_rsp(2, ok_r, d, e, lat);
    lat_override = 0;
    checks++; if (!(ok_i && ok_r) || e !== 1'b0 || d !== 16'd34 || lat != 64) begin
      errors++; $display("FAIL timeout_edge_done: got data=%0d err=%b lat=%0d expected 34 err=0 lat=64", d, e, lat);
    end
    issue(3, 5'd6, ok_i);
    await_rsp(3, ok_r, d, e, lat);
    checks++; if (!(ok_i && ok_r) || e !== 1'b0 || d !== 16'd8) begin errors++; $display("FAIL timeout_next_job: got data=%0d err=%b expected 8 err=0", d, e); end
  endtask

  task automatic test_reset_mid_job();
    bit ok_i, ok_r; logic [15:0] d; logic e; int lat, r0; logic [32:0] got;
    issue(0, 5'd20, ok_i);
    repeat (5) step();
    checks++; if (!ok_i || busy !== 1'b1) begin errors++; $display("FAIL midjob_busy: got ok=%0d busy=%b expected 1/1", ok_i, busy); end
    r0 = rsp_rise;
    reset_n = 1'b0;
    step();
    got = {busy, bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, calc_begin, calc_input_s, calc_reset};
    checks++; if (got !== {1'b0, 4'd0, 4'd0, 16'd0, 1'b0, 1'b0, 5'd0, 1'b1}) begin
      errors++; $display("FAIL midjob_reset_values: got %h expected %h", got, {1'b0, 4'd0, 4'd0, 16'd0, 1'b0, 1'b0, 5'd0, 1'b1});
    end
    reset_n = 1'b1;
    repeat (40) step();
    checks++; if (rsp_rise != r0) begin errors++; $display("FAIL midjob_no_rsp: got %0d responses expected 0", rsp_rise - r0); end
    issue(0, 5'd20, ok_i);
    await_rsp(0, ok_r, d, e, lat);
    checks++; if (!(ok_i && ok_r) || d !== 16'd6765 || e !== 1'b0) begin errors++; $display("FAIL midjob_rerun: got %0d err=%b expected 6765 err=0", d, e); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_range();
    test_round_robin();
    test_back_pressure();
    test_timeout();
    test_reset_mid_job();
    checks++; if (oh_viol != 0) begin errors++; $display("FAIL onehot_outputs: got %0d violations expected 0", oh_viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule
